run_sequencer: RTL and testbench

Host-side job controller that sits directly upstream of top_level.
- Preloads data memory from a host byte stream.
- Holds the core in reset, releases it, and waits for the core's done flag, with a cycle timeout.
- Streams a result window of data memory back to the host.
- Owns the data-memory port through mem_sel whenever the core is not running.

---
 rtl/seq_pkg.sv | 17 +
 rtl/run_sequencer.sv | 173 +++++++++++++++++
 tb/tb_run_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared widths and state encodings for the run_sequencer host job controller.
package seq_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned ST_W   = 3;

    localparam logic [ST_W-1:0] S_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] S_LOAD     = 3'd1;
    localparam logic [ST_W-1:0] S_CORE_RST = 3'd2;
    localparam logic [ST_W-1:0] S_RUN      = 3'd3;
    localparam logic [ST_W-1:0] S_FETCH    = 3'd4;
    localparam logic [ST_W-1:0] S_SEND     = 3'd5;

endpackage

// File: rtl/run_sequencer.sv
// Host-side job controller: preloads data memory, runs the core under a cycle
// budget, then streams a result window of data memory back to the host.
module run_sequencer
    import seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LOAD_BASE  = 8'h00,
    parameter logic [IDX_W-1:0]  LOAD_LEN   = 9'd64,
    parameter logic [ADDR_W-1:0] RES_BASE   = 8'h40,
    parameter logic [IDX_W-1:0]  RES_LEN    = 9'd32,
    parameter int unsigned       RST_CYCLES = 4,
    parameter logic [CNT_W-1:0]  MAX_CYCLES = 16'd4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              core_reset,
    input  logic              core_done,
    output logic              mem_sel,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dat_in,
    input  logic [DATA_W-1:0] mem_dat_out,
    output logic              busy,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles
);

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [IDX_W-1:0]  w_idx_inc;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  r_rst_cnt;
    logic [CNT_W-1:0]  w_rst_cnt_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_core_reset;
    logic              r_mem_sel;
    logic              r_busy;
    logic              w_load_acc;

    // State and datapath registers; handshake outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_rst_cnt    <= '0;
            r_timeout    <= 1'b0;
            r_out_data   <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_core_reset <= 1'b1;
            r_mem_sel    <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_timeout    <= w_timeout_nxt;
            r_out_data   <= w_out_data_nxt;
            r_in_ready   <= (w_state_nxt == S_LOAD);
            r_out_valid  <= (w_state_nxt == S_SEND);
            r_core_reset <= (w_state_nxt != S_RUN);
            r_mem_sel    <= (w_state_nxt != S_RUN);
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_rst_cnt_nxt  = r_rst_cnt;
        w_timeout_nxt  = r_timeout;
        w_out_data_nxt = r_out_data;
        w_load_acc     = 1'b0;
        w_idx_inc      = r_idx + IDX_W'(1);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_rst_cnt_nxt = '0;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = (LOAD_LEN == '0) ? S_CORE_RST : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid && r_in_ready) begin
                    w_load_acc = 1'b1;
                    w_idx_nxt  = w_idx_inc;
                    if (w_idx_inc == LOAD_LEN) begin
                        w_rst_cnt_nxt = '0;
                        w_state_nxt   = S_CORE_RST;
                    end
                end
            end
            S_CORE_RST: begin
                if (r_rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                // core_done outranks the budget so a last-cycle finish is not a timeout
                if (core_done) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = (RES_LEN == '0) ? S_IDLE : S_FETCH;
                end else if (r_cnt == MAX_CYCLES - CNT_W'(1)) begin
                    w_cnt_nxt     = MAX_CYCLES;
                    w_timeout_nxt = 1'b1;
                    w_idx_nxt     = '0;
                    w_state_nxt   = (RES_LEN == '0) ? S_IDLE : S_FETCH;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_FETCH: begin
                w_out_data_nxt = mem_dat_out;
                w_state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    w_idx_nxt   = w_idx_inc;
                    w_state_nxt = (w_idx_inc == RES_LEN) ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Memory port: write only on an accepted preload byte, read address only in FETCH
    always_comb begin
        mem_wr_en  = w_load_acc;
        mem_dat_in = w_load_acc ? in_data : '0;
        mem_addr   = '0;
        if (w_load_acc) begin
            mem_addr = LOAD_BASE + r_idx[ADDR_W-1:0];
        end else if (r_state == S_FETCH) begin
            mem_addr = RES_BASE + r_idx[ADDR_W-1:0];
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign core_reset = r_core_reset;
    assign mem_sel    = r_mem_sel;
    assign busy       = r_busy;
    assign timeout    = r_timeout;
    assign cycles     = r_cnt;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with a behavioural data memory and core model.
module tb_run_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        core_reset;
    logic        core_done;
    logic        mem_sel;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_dat_in;
    logic [7:0]  mem_dat_out;
    logic        busy;
    logic        timeout;
    logic [15:0] cycles;

    int checks = 0;
    int errors = 0;
    int wr_count;
    logic [7:0] res0;
    logic [7:0] res1;
    logic [7:0] mem [256];

    typedef struct {
        logic       start;
        logic       in_valid;
        logic [7:0] in_data;
        logic       ir;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] dat;
        logic       cr;
        logic       ms;
        logic       bsy;
    } vec_t;

    vec_t vt [13];

    run_sequencer #(
        .LOAD_BASE (8'hFE),
        .LOAD_LEN  (9'd4),
        .RES_BASE  (8'h40),
        .RES_LEN   (9'd2),
        .RST_CYCLES(4),
        .MAX_CYCLES(16'd20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .core_reset (core_reset),
        .core_done  (core_done),
        .mem_sel    (mem_sel),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_dat_in (mem_dat_in),
        .mem_dat_out(mem_dat_out),
        .busy       (busy),
        .timeout    (timeout),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    // Data memory with external mux: sequencer writes when mem_sel=1, core model writes results otherwise
    assign mem_dat_out = mem[mem_addr];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            wr_count <= 0;
        end else if (mem_sel) begin
            if (mem_wr_en) begin
                mem[mem_addr] <= mem_dat_in;
                wr_count      <= wr_count + 1;
            end
        end else begin
            mem[8'h40] <= res0;
            mem[8'h41] <= res1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic s, input logic v, input logic [7:0] d,
                           input logic ir, input logic wr, input logic [7:0] a, input logic [7:0] dt,
                           input logic cr, input logic ms, input logic b);
        vt[i].start = s;  vt[i].in_valid = v; vt[i].in_data = d;
        vt[i].ir    = ir; vt[i].wr = wr;      vt[i].addr = a;   vt[i].dat = dt;
        vt[i].cr    = cr; vt[i].ms = ms;      vt[i].bsy = b;
    endtask

    // Start a job, stream four preload bytes, and wait until the core is released
    task automatic start_and_load(input string tag);
        int n;
        int guard;
        start = 1'b1;
        cyc();
        start    = 1'b0;
        in_valid = 1'b1;
        n        = 0;
        guard    = 0;
        while (n < 4 && guard < 50) begin
            in_data = 8'hB0 + 8'(n);
            @(negedge clk);
            if (in_ready) n++;
            cyc();
            guard++;
        end
        in_valid = 1'b0;
        chk({tag, "_loaded"}, 16'(n), 16'd4);
        guard = 0;
        while (core_reset && guard < 20) begin
            cyc();
            guard++;
        end
        chk({tag, "_core_released"}, 16'(core_reset), 16'd0);
    endtask

    task automatic job(input string tag, input int done_at, input logic [7:0] e0, input logic [7:0] e1,
                       input int exp_run, input logic [15:0] exp_cyc, input logic exp_to);
        int run_n;
        int got;
        int guard;
        logic [7:0] rx [4];
        res0 = e0;
        res1 = e1;
        start_and_load(tag);
        run_n = 0;
        while (!mem_sel && run_n < 100) begin
            run_n++;
            core_done = (run_n == done_at);
            cyc();
        end
        core_done = 1'b0;
        chk({tag, "_run_cycles"}, 16'(run_n), 16'(exp_run));
        chk({tag, "_cycles"}, cycles, exp_cyc);
        chk({tag, "_timeout"}, 16'(timeout), 16'(exp_to));
        out_ready = 1'b1;
        got       = 0;
        guard     = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            if (out_valid && got < 4) begin
                rx[got] = out_data;
                got++;
            end
            cyc();
            guard++;
        end
        out_ready = 1'b0;
        chk({tag, "_rx_count"}, 16'(got), 16'd2);
        if (got >= 2) begin
            chk({tag, "_rx0"}, 16'(rx[0]), 16'(e0));
            chk({tag, "_rx1"}, 16'(rx[1]), 16'(e1));
        end
        chk({tag, "_idle"}, 16'(busy), 16'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        core_done = 1'b0;
        res0      = 8'hA5;
        res1      = 8'h5A;

        // Preload with gaps and wrapping address, then the core reset window and first RUN cycle
        set_vec(0,  1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 0);
        set_vec(1,  0, 0, 8'h77, 1, 0, 8'h00, 8'h00, 1, 1, 1);
        set_vec(2,  0, 1, 8'h11, 1, 1, 8'hFE, 8'h11, 1, 1, 1);
        set_vec(3,  0, 0, 8'h55, 1, 0, 8'h00, 8'h00, 1, 1, 1);
        set_vec(4,  0, 1, 8'h22, 1, 1, 8'hFF, 8'h22, 1, 1, 1);
        set_vec(5,  0, 1, 8'h33, 1, 1, 8'h00, 8'h33, 1, 1, 1);
        set_vec(6,  0, 0, 8'h66, 1, 0, 8'h00, 8'h00, 1, 1, 1);
        set_vec(7,  0, 1, 8'h44, 1, 1, 8'h01, 8'h44, 1, 1, 1);
        for (int i = 8; i < 12; i++) set_vec(i, 0, 1, 8'h99, 0, 0, 8'h00, 8'h00, 1, 1, 1);
        set_vec(12, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1);

        repeat (3) cyc();
        @(negedge clk);
        chk("rst_core_reset", 16'(core_reset), 16'd1);
        chk("rst_mem_sel",    16'(mem_sel),    16'd1);
        chk("rst_in_ready",   16'(in_ready),   16'd0);
        chk("rst_out_valid",  16'(out_valid),  16'd0);
        chk("rst_out_data",   16'(out_data),   16'd0);
        chk("rst_mem_wr_en",  16'(mem_wr_en),  16'd0);
        chk("rst_mem_addr",   16'(mem_addr),   16'd0);
        chk("rst_busy",       16'(busy),       16'd0);
        chk("rst_timeout",    16'(timeout),    16'd0);
        chk("rst_cycles",     cycles,          16'd0);
        cyc();
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 13; i++) begin
            start    = vt[i].start;
            in_valid = vt[i].in_valid;
            in_data  = vt[i].in_data;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i),   16'(in_ready),   16'(vt[i].ir));
            chk($sformatf("v%0d_wr_en", i),      16'(mem_wr_en),  16'(vt[i].wr));
            chk($sformatf("v%0d_addr", i),       16'(mem_addr),   16'(vt[i].addr));
            chk($sformatf("v%0d_dat_in", i),     16'(mem_dat_in), 16'(vt[i].dat));
            chk($sformatf("v%0d_core_reset", i), 16'(core_reset), 16'(vt[i].cr));
            chk($sformatf("v%0d_mem_sel", i),    16'(mem_sel),    16'(vt[i].ms));
            chk($sformatf("v%0d_busy", i),       16'(busy),       16'(vt[i].bsy));
            cyc();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("j1_wr_count", 16'(wr_count), 16'd4);
        chk("j1_mem_fe", 16'(mem[8'hFE]), 16'h11);
        chk("j1_mem_ff", 16'(mem[8'hFF]), 16'h22);
        chk("j1_mem_00", 16'(mem[8'h00]), 16'h33);
        chk("j1_mem_01", 16'(mem[8'h01]), 16'h44);

        // RUN cycles 2..10 with a stray start, then core_done in cycle 11
        for (int k = 2; k <= 10; k++) begin
            start = (k == 5);
            @(negedge clk);
            if (k == 6) chk("j1_cycles_mid", cycles, 16'd5);
            cyc();
        end
        start     = 1'b0;
        core_done = 1'b1;
        @(negedge clk);
        chk("j1_cycles_at_done", cycles, 16'd10);
        chk("j1_mem_sel_run", 16'(mem_sel), 16'd0);
        cyc();
        core_done = 1'b0;
        @(negedge clk);
        chk("j1_fetch_mem_sel", 16'(mem_sel), 16'd1);
        chk("j1_fetch_core_reset", 16'(core_reset), 16'd1);
        chk("j1_fetch_addr", 16'(mem_addr), 16'h40);
        chk("j1_cycles", cycles, 16'd10);
        chk("j1_timeout", 16'(timeout), 16'd0);
        chk("j1_fetch_valid", 16'(out_valid), 16'd0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("j1_hold%0d_valid", k), 16'(out_valid), 16'd1);
            chk($sformatf("j1_hold%0d_data", k), 16'(out_data), 16'hA5);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("j1_b0_data", 16'(out_data), 16'hA5);
        cyc();
        out_ready = 1'b0;
        @(negedge clk);
        chk("j1_fetch2_valid", 16'(out_valid), 16'd0);
        chk("j1_fetch2_addr", 16'(mem_addr), 16'h41);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk("j1_b1_valid", 16'(out_valid), 16'd1);
        chk("j1_b1_data", 16'(out_data), 16'h5A);
        cyc();
        out_ready = 1'b0;
        @(negedge clk);
        chk("j1_end_busy", 16'(busy), 16'd0);
        chk("j1_end_valid", 16'(out_valid), 16'd0);
        chk("j1_end_cycles", cycles, 16'd10);
        chk("j1_end_core_reset", 16'(core_reset), 16'd1);
        cyc();

        // Budget expiry: 20 RUN cycles, then readback still proceeds
        job("j2", 0, 8'hC3, 8'h3C, 20, 16'd20, 1'b1);
        chk("j2_wr_count", 16'(wr_count), 16'd8);
        repeat (3) cyc();
        chk("j2_timeout_hold", 16'(timeout), 16'd1);
        chk("j2_cycles_hold", cycles, 16'd20);

        // Reset mid-RUN
        start_and_load("r1");
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("r1_core_reset", 16'(core_reset), 16'd1);
        chk("r1_mem_sel", 16'(mem_sel), 16'd1);
        chk("r1_out_valid", 16'(out_valid), 16'd0);
        chk("r1_busy", 16'(busy), 16'd0);
        chk("r1_cycles", cycles, 16'd0);
        cyc();

        // Reset mid-SEND
        start_and_load("r2");
        core_done = 1'b1;
        cyc();
        core_done = 1'b0;
        cyc();
        @(negedge clk);
        chk("r2_send_valid", 16'(out_valid), 16'd1);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("r2_core_reset", 16'(core_reset), 16'd1);
        chk("r2_mem_sel", 16'(mem_sel), 16'd1);
        chk("r2_out_valid", 16'(out_valid), 16'd0);
        chk("r2_busy", 16'(busy), 16'd0);
        chk("r2_out_data", 16'(out_data), 16'd0);
        cyc();

        job("j3", 3, 8'h66, 8'h99, 3, 16'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
